dcache_wb_buffer: RTL and testbench

//  Write-back (victim) buffer sitting directly downstream of the dcache data

---
 rtl/dcache_wb_buffer.sv | 227 ++++++++++++++++++++++
 tb/tb_dcache_wb_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer: write-back (victim) buffer behind the dcache eviction port.
// Dirty lines evicted on a fill are held in a small circular FIFO. They drain
// to memory as BUS_STORE requests whenever the arbiter grants the bus. Miss
// probes are answered from the buffer, so memory never returns stale data for
// a line that is still waiting to be written back.
module dcache_wb_buffer #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        evict_en,
  input  logic [ADDR_W-1:0]           evict_addr,
  input  logic [DATA_W-1:0]           evict_data,
  output logic                        wb_full,
  output logic                        wb_empty,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  input  logic                        lookup_en,
  input  logic [ADDR_W-1:0]           lookup_addr,
  output logic                        lookup_hit,
  output logic [DATA_W-1:0]           lookup_data,
  input  logic                        mem_grant,
  output logic [1:0]                  proc2mem_command,
  output logic [ADDR_W-1:0]           proc2mem_addr,
  output logic [DATA_W-1:0]           proc2mem_data,
  input  logic [3:0]                  mem2proc_response,
  output logic                        overflow_err
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WB_DEPTH);

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Two addresses name the same 8-byte line when everything above the offset agrees.
  function automatic logic line_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a[ADDR_W-1:3] == b[ADDR_W-1:3]);
  endfunction

  logic              valid_r [WB_DEPTH];
  logic [ADDR_W-1:0] addr_r  [WB_DEPTH];
  logic [DATA_W-1:0] data_r  [WB_DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  state_t            state_r;
  state_t            state_next_s;

  logic              full_s;
  logic              pop_s;
  logic              accept_s;
  logic              evict_hit_s;
  logic [PTR_W-1:0]  evict_idx_s;
  logic              coalesce_s;
  logic              push_s;
  logic [CNT_W-1:0]  count_next_s;
  logic              unused_s;

  assign full_s       = (count_r == CNT_FULL);
  assign wb_full      = full_s;
  assign wb_empty     = (count_r == {CNT_W{1'b0}});
  assign wb_count     = count_r;
  assign overflow_err = overflow_r;
  // Offset bits of the probe address play no part in the line compare.
  assign unused_s     = ^lookup_addr[2:0];

  // The head entry retires when the granted store is acknowledged.
  assign pop_s    = (state_r == ISSUE) && mem_grant && (mem2proc_response != 4'h0);
  // A full buffer drops the eviction outright, even one that would coalesce.
  assign accept_s = evict_en && !full_s;

  // Find a valid entry holding the evicted line; a head being popped this cycle is excluded.
  always_comb begin
    evict_hit_s = 1'b0;
    evict_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (valid_r[i] && line_match(addr_r[i], evict_addr) &&
          !(pop_s && (head_r == PTR_W'(i)))) begin
        evict_hit_s = 1'b1;
        evict_idx_s = PTR_W'(i);
      end else begin
        evict_hit_s = evict_hit_s;
      end
    end
  end

  assign coalesce_s = accept_s && evict_hit_s;
  assign push_s     = accept_s && !evict_hit_s;

  // Occupancy after this edge; a simultaneous push and pop cancel.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Drain FSM next state: issue while anything is buffered.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != {CNT_W{1'b0}}) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (pop_s && (count_next_s == {CNT_W{1'b0}})) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ISSUE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Bus request: head entry is presented throughout ISSUE, command only while granted.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = {ADDR_W{1'b0}};
    proc2mem_data    = {DATA_W{1'b0}};
    if (state_r == ISSUE) begin
      proc2mem_addr = addr_r[head_r];
      proc2mem_data = data_r[head_r];
      if (mem_grant) begin
        proc2mem_command = BUS_STORE;
      end else begin
        proc2mem_command = BUS_NONE;
      end
    end else begin
      proc2mem_command = BUS_NONE;
    end
  end

  // Miss probe CAM: scan oldest to youngest so the youngest match wins,
  // then let an accepted same-cycle eviction of that line override everything.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = {DATA_W{1'b0}};
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (valid_r[head_r + PTR_W'(i)] &&
          line_match(addr_r[head_r + PTR_W'(i)], lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_r[head_r + PTR_W'(i)];
      end else begin
        lookup_hit  = lookup_hit;
      end
    end
    if (accept_s && line_match(evict_addr, lookup_addr)) begin
      lookup_hit  = 1'b1;
      lookup_data = evict_data;
    end else begin
      lookup_hit  = lookup_hit;
    end
    if (!lookup_en) begin
      lookup_hit  = 1'b0;
      lookup_data = {DATA_W{1'b0}};
    end else begin
      lookup_hit  = lookup_hit;
    end
  end

  // FSM, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (evict_en && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage: allocate at tail, coalesce in place, invalidate on pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        addr_r[i]  <= {ADDR_W{1'b0}};
        data_r[i]  <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        valid_r[tail_r] <= 1'b1;
        addr_r[tail_r]  <= evict_addr;
        data_r[tail_r]  <= evict_data;
      end
      if (coalesce_s) begin
        data_r[evict_idx_s] <= evict_data;
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer. Inputs change just after the falling
// edge; outputs are sampled 1ns later, well clear of the rising edge.
module tb_dcache_wb_buffer;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;

  logic        clock;
  logic        reset;
  logic        evict_en;
  logic [31:0] evict_addr;
  logic [63:0] evict_data;
  logic        wb_full;
  logic        wb_empty;
  logic [2:0]  wb_count;
  logic        lookup_en;
  logic [31:0] lookup_addr;
  logic        lookup_hit;
  logic [63:0] lookup_data;
  logic        mem_grant;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic        overflow_err;

  int compared;
  int mismatched;

  dcache_wb_buffer #(.WB_DEPTH(4), .ADDR_W(32), .DATA_W(64)) dut (
    .clock             (clock),
    .reset             (reset),
    .evict_en          (evict_en),
    .evict_addr        (evict_addr),
    .evict_data        (evict_data),
    .wb_full           (wb_full),
    .wb_empty          (wb_empty),
    .wb_count          (wb_count),
    .lookup_en         (lookup_en),
    .lookup_addr       (lookup_addr),
    .lookup_hit        (lookup_hit),
    .lookup_data       (lookup_data),
    .mem_grant         (mem_grant),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .overflow_err      (overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared          = 0;
    mismatched        = 0;
    reset             = 1'b0;
    evict_en          = 1'b0;
    evict_addr        = 32'h0;
    evict_data        = 64'h0;
    lookup_en         = 1'b0;
    lookup_addr       = 32'h0;
    mem_grant         = 1'b0;
    mem2proc_response = 4'h0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_cmd",   {62'h0, proc2mem_command}, {62'h0, BUS_NONE});
    chk("rst_count", {61'h0, wb_count}, 64'd0);
    chk("rst_empty", {63'h0, wb_empty}, 64'd1);
    chk("rst_full",  {63'h0, wb_full}, 64'd0);
    chk("rst_ovf",   {63'h0, overflow_err}, 64'd0);
    chk("rst_addr",  {32'h0, proc2mem_addr}, 64'h0);
    chk("rst_data",  proc2mem_data, 64'h0);
    chk("rst_hit",   {63'h0, lookup_hit}, 64'd0);

    // ---- two evictions drained back to back ----
    @(negedge clock);
    evict_en = 1'b1; evict_addr = 32'h100; evict_data = 64'hD0D0_0000_0000_00D0;
    #1;
    chk("t2_cnt0", {61'h0, wb_count}, 64'd0);
    @(negedge clock);
    evict_addr = 32'h108; evict_data = 64'hD1D1_0000_0000_00D1;
    mem_grant = 1'b1; mem2proc_response = 4'h1;
    #1;
    chk("t2_cnt1",     {61'h0, wb_count}, 64'd1);
    chk("t2_idle_cmd", {62'h0, proc2mem_command}, {62'h0, BUS_NONE});
    @(negedge clock);
    evict_en = 1'b0;
    #1;
    chk("t2_cnt2",  {61'h0, wb_count}, 64'd2);
    chk("t2_cmd0",  {62'h0, proc2mem_command}, {62'h0, BUS_STORE});
    chk("t2_addr0", {32'h0, proc2mem_addr}, 64'h100);
    chk("t2_data0", proc2mem_data, 64'hD0D0_0000_0000_00D0);
    @(negedge clock);
    #1;
    chk("t2_cnt3",  {61'h0, wb_count}, 64'd1);
    chk("t2_cmd1",  {62'h0, proc2mem_command}, {62'h0, BUS_STORE});
    chk("t2_addr1", {32'h0, proc2mem_addr}, 64'h108);
    chk("t2_data1", proc2mem_data, 64'hD1D1_0000_0000_00D1);
    @(negedge clock);
    #1;
    chk("t2_cnt4",  {61'h0, wb_count}, 64'd0);
    chk("t2_empty", {63'h0, wb_empty}, 64'd1);
    chk("t2_cmd2",  {62'h0, proc2mem_command}, {62'h0, BUS_NONE});
    mem_grant = 1'b0; mem2proc_response = 4'h0;

    // ---- coalescing: 0x200/A, 0x208/B, 0x200/C ----
    @(negedge clock);
    evict_en = 1'b1; evict_addr = 32'h200; evict_data = 64'hAAAA;
    @(negedge clock);
    evict_addr = 32'h208; evict_data = 64'hBBBB;
    @(negedge clock);
    evict_addr = 32'h200; evict_data = 64'hCCCC;
    @(negedge clock);
    evict_en = 1'b0;
    lookup_en = 1'b0; lookup_addr = 32'h200;
    #1;
    chk("t4_cnt",     {61'h0, wb_count}, 64'd2);
    chk("t4_nogrant", {62'h0, proc2mem_command}, {62'h0, BUS_NONE});
    chk("t4_headadr", {32'h0, proc2mem_addr}, 64'h200);
    chk("t4_headdat", proc2mem_data, 64'hCCCC);
    chk("lk_dis_hit", {63'h0, lookup_hit}, 64'd0);
    chk("lk_dis_dat", lookup_data, 64'h0);
    lookup_en = 1'b1; lookup_addr = 32'h204;
    #1;
    chk("lk_200_hit", {63'h0, lookup_hit}, 64'd1);
    chk("lk_200_dat", lookup_data, 64'hCCCC);

    // ---- grant without acceptance holds the request ----
    lookup_en = 1'b0;
    mem_grant = 1'b1; mem2proc_response = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      chk("t5_cmd",  {62'h0, proc2mem_command}, {62'h0, BUS_STORE});
      chk("t5_addr", {32'h0, proc2mem_addr}, 64'h200);
      chk("t5_data", proc2mem_data, 64'hCCCC);
      chk("t5_cnt",  {61'h0, wb_count}, 64'd2);
    end
    @(negedge clock);
    mem2proc_response = 4'h5;
    #1;
    chk("t5_acc_adr", {32'h0, proc2mem_addr}, 64'h200);
    @(negedge clock);
    mem_grant = 1'b0; mem2proc_response = 4'h0;
    #1;
    chk("t5_popcnt", {61'h0, wb_count}, 64'd1);
    chk("t4_adr2",   {32'h0, proc2mem_addr}, 64'h208);
    chk("t4_dat2",   proc2mem_data, 64'hBBBB);

    // ---- lookup of a buffered line, then same-cycle eviction forwarding ----
    lookup_en = 1'b1; lookup_addr = 32'h20C;
    #1;
    chk("t6_hit",  {63'h0, lookup_hit}, 64'd1);
    chk("t6_data", lookup_data, 64'hBBBB);
    evict_en = 1'b1; evict_addr = 32'h208; evict_data = 64'hEEEE;
    #1;
    chk("t6_fwd_hit",  {63'h0, lookup_hit}, 64'd1);
    chk("t6_fwd_data", lookup_data, 64'hEEEE);
    @(negedge clock);
    evict_en = 1'b0; lookup_en = 1'b0;
    mem_grant = 1'b1; mem2proc_response = 4'h1;
    #1;
    chk("t6_cnt",  {61'h0, wb_count}, 64'd1);
    chk("t6_drn",  proc2mem_data, 64'hEEEE);
    @(negedge clock);
    mem_grant = 1'b0; mem2proc_response = 4'h0;
    lookup_en = 1'b1; lookup_addr = 32'h208;
    #1;
    chk("t6_empty", {63'h0, wb_empty}, 64'd1);
    chk("t6_miss",  {63'h0, lookup_hit}, 64'd0);
    chk("t6_missd", lookup_data, 64'h0);
    lookup_en = 1'b0;

    // ---- fill to full, overflow, drain order ----
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      evict_en = 1'b1; evict_addr = 32'h300 + 32'(k * 8); evict_data = 64'hF000 + 64'(k);
    end
    @(negedge clock);
    evict_en = 1'b0;
    #1;
    chk("t3_full", {63'h0, wb_full}, 64'd1);
    chk("t3_cnt4", {61'h0, wb_count}, 64'd4);
    chk("t3_ovf0", {63'h0, overflow_err}, 64'd0);
    @(negedge clock);
    evict_en = 1'b1; evict_addr = 32'h320; evict_data = 64'hF004;
    @(negedge clock);
    evict_en = 1'b0;
    #1;
    chk("t3_ovf1",  {63'h0, overflow_err}, 64'd1);
    chk("t3_cnt4b", {61'h0, wb_count}, 64'd4);
    mem_grant = 1'b1; mem2proc_response = 4'h1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_drn_adr", {32'h0, proc2mem_addr}, 64'h300 + 64'(k * 8));
      chk("t3_drn_dat", proc2mem_data, 64'hF000 + 64'(k));
      chk("t3_drn_cnt", {61'h0, wb_count}, 64'(4 - k));
      chk("t3_drn_ful", {63'h0, wb_full}, (k == 0) ? 64'd1 : 64'd0);
      @(negedge clock);
    end
    #1;
    chk("t3_empty",  {63'h0, wb_empty}, 64'd1);
    chk("t3_cmdend", {62'h0, proc2mem_command}, {62'h0, BUS_NONE});
    chk("t3_sticky", {63'h0, overflow_err}, 64'd1);
    mem_grant = 1'b0; mem2proc_response = 4'h0;

    // ---- reset while a store is in flight ----
    @(negedge clock);
    evict_en = 1'b1; evict_addr = 32'h400; evict_data = 64'h6666;
    @(negedge clock);
    evict_en = 1'b0;
    @(negedge clock);
    mem_grant = 1'b1; mem2proc_response = 4'h0;
    #1;
    chk("t1_pre_cmd", {62'h0, proc2mem_command}, {62'h0, BUS_STORE});
    #1;
    reset = 1'b0;
    #1;
    chk("t1_cmd",   {62'h0, proc2mem_command}, {62'h0, BUS_NONE});
    chk("t1_empty", {63'h0, wb_empty}, 64'd1);
    chk("t1_cnt",   {61'h0, wb_count}, 64'd0);
    chk("t1_ovf",   {63'h0, overflow_err}, 64'd0);
    chk("t1_addr",  {32'h0, proc2mem_addr}, 64'h0);
    @(negedge clock);
    reset = 1'b1; mem_grant = 1'b0;
    lookup_en = 1'b1; lookup_addr = 32'h400;
    #1;
    chk("t1_lk_miss", {63'h0, lookup_hit}, 64'd0);
    @(negedge clock);
    #1;
    chk("t1_idle", {62'h0, proc2mem_command}, {62'h0, BUS_NONE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
